qeciphy_rx_packet_chk: RTL

//  Receive-side counterpart of the TX packet generator. Takes aligned 64-bit link words, one per cycle.

---
 rtl/qeciphy_rx_packet_chk.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/qeciphy_rx_packet_chk.sv
// Receive-side frame checker: locks to the FAW, verifies per-group CRC-32 and emits user words.
// Optional QECIPHY_RX_ERR_CNT_EN adds saturating CRC/FAW error counters.
module qeciphy_rx_packet_chk #(
    parameter logic [55:0] FAW_PATTERN = 56'hF6F6_2828_F6F6_28,
    parameter int unsigned MAX_FAW_ERR = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        faw_boundary_i,
    input  logic        crc_boundary_i,
    input  logic [63:0] rx_tdata_i,
    output logic [63:0] m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    output logic        locked_o,
    output logic [2:0]  remote_state_o,
    output logic        remote_rx_rdy_o,
    output logic        crc_err_o,
    output logic        faw_err_o
`ifdef QECIPHY_RX_ERR_CNT_EN
    ,
    output logic [15:0] crc_err_cnt_o,
    output logic [15:0] faw_err_cnt_o
`endif
);

    localparam logic [0:0]  ST_UNLOCKED = 1'b0;
    localparam logic [0:0]  ST_LOCKED   = 1'b1;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [2:0]  MAX_ERR     = 3'(MAX_FAW_ERR);
    localparam logic [2:0]  CRC_SLOT    = 3'd6;

    // One 64-bit word folded into the CRC, MSB first.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in, input logic [63:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 63; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    logic [0:0]  state_q;
    logic [5:0]  wcnt_q;
    logic [2:0]  slot_q;
    logic [31:0] crc_q;
    logic [2:0]  mis_cnt_q;
    logic        bank_sel_q;
    logic        drain_bank_q;
    logic [5:0]  drain_mask_q;
    logic [63:0] bank_q [2][6];

    logic       locked, is_faw_pos, is_crc_pos, is_data_pos, pattern_ok;
    logic       pos_err, pat_err, drop, lock_acq, crc_check, crc_ok, crc_bad;
    logic [5:0] src_mask, pick_onehot;
    logic       src_bank;
    logic [2:0] pick_idx;

    assign locked      = (state_q == ST_LOCKED);
    assign locked_o    = locked;
    assign is_faw_pos  = (wcnt_q == 6'd0);
    assign is_crc_pos  = !is_faw_pos && (slot_q == CRC_SLOT);
    assign is_data_pos = !is_faw_pos && (slot_q != CRC_SLOT);
    assign pattern_ok  = (rx_tdata_i[63:8] == FAW_PATTERN);

    // Boundary flags must agree with the local word count; otherwise alignment is lost.
    assign pos_err   = locked && ((faw_boundary_i != is_faw_pos) || (crc_boundary_i != is_crc_pos));
    assign pat_err   = locked && !pos_err && is_faw_pos && !pattern_ok;
    assign drop      = pos_err || (pat_err && ((mis_cnt_q + 3'd1) >= MAX_ERR));
    assign lock_acq  = !locked && faw_boundary_i && pattern_ok;
    assign crc_check = locked && !pos_err && is_crc_pos;
    assign crc_ok    = crc_check && (crc_q == rx_tdata_i[31:0]);
    assign crc_bad   = crc_check && !crc_ok;

    assign src_mask = crc_ok ? rx_tdata_i[57:52] : drain_mask_q;
    assign src_bank = crc_ok ? bank_sel_q : drain_bank_q;

    // NOTE: defaults are assigned first so no path through this block infers a latch.
    always_comb begin
        pick_idx    = 3'd0;
        pick_onehot = 6'd0;
        for (int k = 5; k >= 0; k--) begin
            if (src_mask[k]) begin
                pick_idx    = 3'(k);
                pick_onehot = 6'd1 << k;
            end
        end
    end

    // NOTE: payload banks are plain storage with no reset; a valid mask always gates reads.
    always_ff @(posedge clk_i) begin
        if (locked && is_data_pos) begin
            bank_q[bank_sel_q][slot_q] <= rx_tdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= ST_UNLOCKED;
            wcnt_q          <= '0;
            slot_q          <= '0;
            crc_q           <= CRC_INIT;
            mis_cnt_q       <= '0;
            bank_sel_q      <= 1'b0;
            drain_bank_q    <= 1'b0;
            drain_mask_q    <= '0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tdata_o  <= '0;
            remote_state_o  <= 3'b001;
            remote_rx_rdy_o <= 1'b0;
            crc_err_o       <= 1'b0;
            faw_err_o       <= 1'b0;
        end else begin
            crc_err_o <= crc_bad;
            faw_err_o <= pos_err || pat_err;
            if (drop) begin
                state_q         <= ST_UNLOCKED;
                mis_cnt_q       <= '0;
                drain_mask_q    <= '0;
                m_axis_tvalid_o <= 1'b0;
                remote_state_o  <= 3'b001;
                remote_rx_rdy_o <= 1'b0;
            end else if (lock_acq) begin
                state_q         <= ST_LOCKED;
                wcnt_q          <= 6'd1;
                slot_q          <= 3'd0;
                mis_cnt_q       <= '0;
                bank_sel_q      <= 1'b0;
                drain_mask_q    <= '0;
                m_axis_tvalid_o <= 1'b0;
                remote_state_o  <= rx_tdata_i[2:0];
                remote_rx_rdy_o <= rx_tdata_i[3];
            end else if (locked) begin
                wcnt_q <= wcnt_q + 6'd1;
                slot_q <= (is_faw_pos || slot_q == CRC_SLOT) ? 3'd0 : slot_q + 3'd1;
                if (is_data_pos) begin
                    crc_q <= crc32_word((slot_q == 3'd0) ? CRC_INIT : crc_q, rx_tdata_i);
                end
                if (is_faw_pos && pattern_ok) begin
                    remote_state_o  <= rx_tdata_i[2:0];
                    remote_rx_rdy_o <= rx_tdata_i[3];
                    mis_cnt_q       <= '0;
                end else if (pat_err) begin
                    mis_cnt_q <= mis_cnt_q + 3'd1;
                end
                if (is_crc_pos) begin
                    bank_sel_q <= ~bank_sel_q;
                end
                // Drain one compacted word per cycle; it runs on through a FAW cycle.
                m_axis_tvalid_o <= |src_mask;
                if (|src_mask) begin
                    m_axis_tdata_o <= bank_q[src_bank][pick_idx];
                end
                drain_mask_q <= src_mask & ~pick_onehot;
                drain_bank_q <= src_bank;
            end else begin
                m_axis_tvalid_o <= 1'b0;
            end
        end
    end

`ifdef QECIPHY_RX_ERR_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_err_cnt_o <= '0;
            faw_err_cnt_o <= '0;
        end else begin
            if (crc_bad && crc_err_cnt_o != 16'hFFFF) begin
                crc_err_cnt_o <= crc_err_cnt_o + 16'd1;
            end
            if ((pos_err || pat_err) && faw_err_cnt_o != 16'hFFFF) begin
                faw_err_cnt_o <= faw_err_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
